pipe_ctrl: RTL and testbench

Central pipeline controller for the three-stage IF/ID/EX core. Observes the instruction in ID (source registers, `ebreak`) and the instruction in EX (destination, multi-cycle busy, control-flow redirect). Drives hold, flush and bubble controls for the PC, the `if_id` register and the `id_ex` register. Also owns the halt sequence after `ebreak` and a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_hazard_det.sv | 26 ++
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID/EX pipeline controller.
package pipe_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 32;

    localparam logic [31:0]       NOP_INST = 32'h0000_0013;
    localparam logic [REG_AW-1:0] REG_X0   = REG_AW'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_hazard_det.sv
// RAW hazard compare between the ID sources and the EX destination (pure combinational).
module pipe_hazard_det
    import pipe_pkg::*;
(
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1_addr,
    input  logic [REG_AW-1:0] i_id_rs2_addr,
    input  logic              i_id_rs1_ren,
    input  logic              i_id_rs2_ren,
    input  logic              i_ex_valid,
    input  logic [REG_AW-1:0] i_ex_rd_addr,
    input  logic              i_ex_reg_wen,
    output logic              o_haz_rs1,
    output logic              o_haz_rs2
);

    logic w_ex_writes;

    // x0 is never a real producer, so a match on it is not a hazard
    assign w_ex_writes = i_id_valid & i_ex_valid & i_ex_reg_wen;
    assign o_haz_rs1   = w_ex_writes & i_id_rs1_ren & (i_id_rs1_addr != REG_X0)
                         & (i_ex_rd_addr == i_id_rs1_addr);
    assign o_haz_rs2   = w_ex_writes & i_id_rs2_ren & (i_id_rs2_addr != REG_X0)
                         & (i_ex_rd_addr == i_id_rs2_addr);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: hold/flush/bubble steering, ebreak halt sequence, stall counter.
// Optional operand forwarding from EX is enabled with `define PIPE_CTRL_FWD_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_ren,
    input  logic              id_rs2_ren,
    input  logic              id_ebreak,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_reg_wen,
    input  logic              ex_busy,
    input  logic              ex_redirect,
    input  logic [XLEN-1:0]   ex_redirect_pc,
    output logic              pc_hold,
    output logic              pc_redirect,
    output logic [XLEN-1:0]   pc_redirect_addr,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_bubble,
    output logic              fwd_rs1,
    output logic              fwd_rs2,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_haz_stall;
    logic             w_cnt_inc;

    pipe_hazard_det u_haz (
        .i_id_valid    (id_valid),
        .i_id_rs1_addr (id_rs1_addr),
        .i_id_rs2_addr (id_rs2_addr),
        .i_id_rs1_ren  (id_rs1_ren),
        .i_id_rs2_ren  (id_rs2_ren),
        .i_ex_valid    (ex_valid),
        .i_ex_rd_addr  (ex_rd_addr),
        .i_ex_reg_wen  (ex_reg_wen),
        .o_haz_rs1     (w_haz_rs1),
        .o_haz_rs2     (w_haz_rs2)
    );

    // With forwarding a hazard never stalls; otherwise any source hazard stalls
`ifdef PIPE_CTRL_FWD_EN
    assign w_haz_stall = 1'b0;
`else
    assign w_haz_stall = w_haz_rs1 | w_haz_rs2;
`endif

    assign pc_redirect_addr = ex_redirect_pc;
    assign stall_cnt        = r_stall_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and control outputs; all controls forced low while reset is held
    always_comb begin
        w_next_state = r_state;
        pc_hold      = 1'b0;
        pc_redirect  = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        fwd_rs1      = 1'b0;
        fwd_rs2      = 1'b0;
        halted       = 1'b0;
        if (rst_n) begin
            case (r_state)
                RUN: begin
                    if (ex_busy) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                    end else if (ex_valid && ex_redirect) begin
                        pc_redirect  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (w_haz_stall) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
`ifdef PIPE_CTRL_FWD_EN
                        fwd_rs1 = w_haz_rs1;
                        fwd_rs2 = w_haz_rs2;
`endif
                        // ebreak moves into EX; stop fetching behind it
                        if (id_valid && id_ebreak) begin
                            pc_hold      = 1'b1;
                            if_id_flush  = 1'b1;
                            w_next_state = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_next_state = HALTED;
                end
                HALTED: begin
                    halted       = 1'b1;
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    assign w_cnt_inc = (r_state == RUN) & pc_hold & ~pc_redirect & (r_stall_cnt != CNT_MAX);

    // Saturating stall-cycle counter, live only while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (builds with or without PIPE_CTRL_FWD_EN).
module tb_pipe_ctrl;

    localparam int unsigned XLEN = 32;

    // Control vector order: pc_hold, pc_redirect, if_id_hold, if_id_flush,
    // id_ex_hold, id_ex_bubble, fwd_rs1, fwd_rs2, halted
    localparam logic [8:0] C_NONE  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_STALL = 9'b1_0_1_0_0_1_0_0_0;
    localparam logic [8:0] C_REDIR = 9'b0_1_0_1_0_1_0_0_0;
    localparam logic [8:0] C_BUSY  = 9'b1_0_1_0_1_0_0_0_0;
    localparam logic [8:0] C_EBRK  = 9'b1_0_0_1_0_0_0_0_0;
    localparam logic [8:0] C_HALT  = 9'b1_0_1_0_0_1_0_0_1;
`ifdef PIPE_CTRL_FWD_EN
    localparam logic [8:0] C_HAZ1  = 9'b0_0_0_0_0_0_1_0_0;
    localparam logic [8:0] C_HAZ2  = 9'b0_0_0_0_0_0_0_1_0;
    localparam int         HAZ_INC = 0;
`else
    localparam logic [8:0] C_HAZ1  = C_STALL;
    localparam logic [8:0] C_HAZ2  = C_STALL;
    localparam int         HAZ_INC = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid, id_rs1_ren, id_rs2_ren, id_ebreak;
    logic [4:0]      id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic            ex_valid, ex_reg_wen, ex_busy, ex_redirect;
    logic [XLEN-1:0] ex_redirect_pc;
    logic            pc_hold, pc_redirect, if_id_hold, if_id_flush;
    logic            id_ex_hold, id_ex_bubble, fwd_rs1, fwd_rs2, halted;
    logic [XLEN-1:0] pc_redirect_addr;
    logic [31:0]     stall_cnt;
    logic [8:0]      ctl;
    logic [31:0]     exp_cnt = 32'd0;
    int              total = 0;
    int              bad = 0;

    assign ctl = {pc_hold, pc_redirect, if_id_hold, if_id_flush,
                  id_ex_hold, id_ex_bubble, fwd_rs1, fwd_rs2, halted};

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_valid         (id_valid),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs2_addr      (id_rs2_addr),
        .id_rs1_ren       (id_rs1_ren),
        .id_rs2_ren       (id_rs2_ren),
        .id_ebreak        (id_ebreak),
        .ex_valid         (ex_valid),
        .ex_rd_addr       (ex_rd_addr),
        .ex_reg_wen       (ex_reg_wen),
        .ex_busy          (ex_busy),
        .ex_redirect      (ex_redirect),
        .ex_redirect_pc   (ex_redirect_pc),
        .pc_hold          (pc_hold),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .if_id_hold       (if_id_hold),
        .if_id_flush      (if_id_flush),
        .id_ex_hold       (id_ex_hold),
        .id_ex_bubble     (id_ex_bubble),
        .fwd_rs1          (fwd_rs1),
        .fwd_rs2          (fwd_rs2),
        .halted           (halted),
        .stall_cnt        (stall_cnt)
    );

    task automatic idle();
        id_valid = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; id_ebreak = 1'b0;
        ex_valid = 1'b0; ex_rd_addr = 5'd0; ex_reg_wen = 1'b0;
        ex_busy = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        ex_busy = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1;
        id_valid = 1'b1; id_ebreak = 1'b1;
        #2;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_NONE); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", stall_cnt); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL reset_idle_ctl got=%b want=%b", ctl, C_NONE); end
    endtask

    task automatic test_hazard();
        idle();
        ex_valid = 1'b1; ex_rd_addr = 5'd5; ex_reg_wen = 1'b1;
        id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs1_ren = 1'b1;
        id_rs2_addr = 5'd3; id_rs2_ren = 1'b1;
        #1;
        total++; if (ctl !== C_HAZ1) begin bad++; $display("FAIL haz_rs1_ctl got=%b want=%b", ctl, C_HAZ1); end
        tick();
        exp_cnt = exp_cnt + 32'(HAZ_INC);
        idle();
        #1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL haz_rs1_cnt got=%h want=%h", stall_cnt, exp_cnt); end
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL haz_clear got=%b want=%b", ctl, C_NONE); end
        ex_valid = 1'b1; ex_rd_addr = 5'd9; ex_reg_wen = 1'b1;
        id_valid = 1'b1; id_rs1_addr = 5'd4; id_rs1_ren = 1'b1;
        id_rs2_addr = 5'd9; id_rs2_ren = 1'b1;
        #1;
        total++; if (ctl !== C_HAZ2) begin bad++; $display("FAIL haz_rs2_ctl got=%b want=%b", ctl, C_HAZ2); end
        tick();
        exp_cnt = exp_cnt + 32'(HAZ_INC);
        idle();
        #1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL haz_rs2_cnt got=%h want=%h", stall_cnt, exp_cnt); end
    endtask

    task automatic test_x0_and_gating();
        idle();
        ex_valid = 1'b1; ex_rd_addr = 5'd0; ex_reg_wen = 1'b1;
        id_valid = 1'b1; id_rs1_addr = 5'd0; id_rs1_ren = 1'b1;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL x0_ctl got=%b want=%b", ctl, C_NONE); end
        ex_rd_addr = 5'd7; id_rs1_addr = 5'd1; id_rs2_addr = 5'd7; id_rs2_ren = 1'b0;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL ren0_ctl got=%b want=%b", ctl, C_NONE); end
        id_rs2_ren = 1'b1; ex_reg_wen = 1'b0;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL wen0_ctl got=%b want=%b", ctl, C_NONE); end
        tick();
        idle();
        #1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL x0_cnt got=%h want=%h", stall_cnt, exp_cnt); end
    endtask

    task automatic test_redirect();
        idle();
        ex_valid = 1'b1; ex_rd_addr = 5'd5; ex_reg_wen = 1'b1;
        id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs1_ren = 1'b1; id_ebreak = 1'b1;
        ex_redirect = 1'b1; ex_redirect_pc = 32'h8000_0100;
        #1;
        total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL redir_ctl got=%b want=%b", ctl, C_REDIR); end
        total++; if (pc_redirect_addr !== 32'h8000_0100) begin bad++; $display("FAIL redir_addr got=%h want=80000100", pc_redirect_addr); end
        tick();
        idle();
        #1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL redir_cnt got=%h want=%h", stall_cnt, exp_cnt); end
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL redir_no_drain got=%b want=%b", ctl, C_NONE); end
        ex_redirect = 1'b1;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL redir_invalid got=%b want=%b", ctl, C_NONE); end
        idle();
    endtask

    task automatic test_busy();
        idle();
        ex_busy = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctl !== C_BUSY) begin bad++; $display("FAIL busy_ctl[%0d] got=%b want=%b", i, ctl, C_BUSY); end
            tick();
        end
        exp_cnt = exp_cnt + 32'd3;
        ex_busy = 1'b0;
        #1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL busy_cnt got=%h want=%h", stall_cnt, exp_cnt); end
        total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL busy_release got=%b want=%b", ctl, C_REDIR); end
        total++; if (pc_redirect_addr !== 32'h1234_5678) begin bad++; $display("FAIL busy_addr got=%h want=12345678", pc_redirect_addr); end
        tick();
        idle();
        #1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL busy_redir_cnt got=%h want=%h", stall_cnt, exp_cnt); end
    endtask

    task automatic test_ebreak();
        idle();
        id_valid = 1'b1; id_ebreak = 1'b1;
        #1;
        total++; if (ctl !== C_EBRK) begin bad++; $display("FAIL ebrk_ctl got=%b want=%b", ctl, C_EBRK); end
        tick();
        exp_cnt = exp_cnt + 32'd1;
        ex_busy = 1'b1; ex_valid = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0040;
        #1;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL drain_ctl got=%b want=%b", ctl, C_STALL); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL ebrk_cnt got=%h want=%h", stall_cnt, exp_cnt); end
        tick();
        #1;
        total++; if (ctl !== C_HALT) begin bad++; $display("FAIL halt_ctl got=%b want=%b", ctl, C_HALT); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL drain_cnt got=%h want=%h", stall_cnt, exp_cnt); end
        ex_busy = 1'b0;
        repeat (3) tick();
        total++; if (ctl !== C_HALT) begin bad++; $display("FAIL halt_stay got=%b want=%b", ctl, C_HALT); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL halt_cnt got=%h want=%h", stall_cnt, exp_cnt); end
        rst_n = 1'b0;
        #1;
        total++; if (ctl !== C_NONE) begin bad++; $display("FAIL halt_rst_ctl got=%b want=%b", ctl, C_NONE); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL halt_rst_cnt got=%h want=0", stall_cnt); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_cnt = 32'd0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_cleared got=%b want=0", halted); end
        ex_busy = 1'b1;
        #1;
        total++; if (ctl !== C_BUSY) begin bad++; $display("FAIL post_rst_run got=%b want=%b", ctl, C_BUSY); end
        idle();
    endtask

    task automatic test_saturation();
        idle();
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_cnt;
        #1;
        total++; if (stall_cnt !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sat_preload got=%h want=fffffffd", stall_cnt); end
        ex_busy = 1'b1;
        tick();
        total++; if (stall_cnt !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_step1 got=%h want=fffffffe", stall_cnt); end
        tick();
        total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_step2 got=%h want=ffffffff", stall_cnt); end
        tick();
        total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffffffff", stall_cnt); end
        idle();
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_x0_and_gating();
        test_redirect();
        test_busy();
        test_ebreak();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
